// File: rtl/ptw_pkg.sv
// Shared types and constants for the Sv39 page-table walker.
package ptw_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WRITE,
    S_FAULT
  } ptw_state_e;

  localparam int unsigned PTE_V       = 0;
  localparam int unsigned PTE_R       = 1;
  localparam int unsigned PTE_W       = 2;
  localparam int unsigned PTE_X       = 3;
  localparam int unsigned PTE_PPN_LSB = 10;
  localparam int unsigned PTE_PPN_MSB = 53;

  localparam logic [1:0] PAGE_4K = 2'b00;
  localparam logic [1:0] PAGE_2M = 2'b01;
  localparam logic [1:0] PAGE_1G = 2'b10;

  localparam logic [3:0] SATP_MODE_SV39 = 4'd8;

endpackage

// File: rtl/ptw_sv39_ptecheck.sv
// Combinational Sv39 PTE classifier: leaf, pointer to next level, or walk fault.
module ptecheck
  import ptw_pkg::*;
(
  input  logic [63:0] pte_i,
  input  logic [1:0]  level_i,
  output logic        leaf_o,
  output logic        nonleaf_o,
  output logic        fault_o
);

  logic invalid;
  logic is_leaf;
  logic misaligned;
  logic unused_bits;

  assign invalid = ~pte_i[PTE_V] | (~pte_i[PTE_R] & pte_i[PTE_W]) | (|pte_i[63:54]);
  assign is_leaf = pte_i[PTE_R] | pte_i[PTE_X];

  // Superpage leaves must have their low PPN fields cleared.
  assign misaligned = ((level_i == PAGE_1G) && (|pte_i[27:10])) ||
                      ((level_i == PAGE_2M) && (|pte_i[18:10]));

  assign leaf_o    = ~invalid & is_leaf & ~misaligned;
  assign nonleaf_o = ~invalid & ~is_leaf & (level_i != PAGE_4K);
  assign fault_o   = invalid | (is_leaf & misaligned) | (~is_leaf & (level_i == PAGE_4K));

  assign unused_bits = ^{pte_i[53:28], pte_i[9:4]};

endmodule

// File: rtl/ptw_sv39.sv
// Sv39 hardware page-table walker: serves ITLB/DTLB misses through one
// request/grant/valid memory port and writes the leaf PTE back to the TLB.
module ptw_sv39
  import ptw_pkg::*;
#(
  parameter int unsigned PA_BITS = 56,
  parameter int unsigned XLEN    = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [XLEN-1:0]    SATP_REGW,
  input  logic               ITLBMissF,
  input  logic               DTLBMissM,
  input  logic [XLEN-1:0]    PCF,
  input  logic [XLEN-1:0]    IEUAdrM,
  input  logic               TLBFlush,
  output logic               HPTWReq,
  output logic [PA_BITS-1:0] HPTWAdr,
  input  logic               HPTWGnt,
  input  logic               HPTWValid,
  input  logic [XLEN-1:0]    HPTWReadPTE,
  output logic               ITLBWriteF,
  output logic               DTLBWriteM,
  output logic [XLEN-1:0]    PTE,
  output logic [1:0]         PageTypeWriteVal,
  output logic               WalkFault,
  output logic               WalkFaultInstr,
  output logic               SelHPTW
);

  ptw_state_e state_q, state_d;
  logic [1:0]  level_q, level_d;
  logic [38:0] va_q, va_d;
  logic        side_q, side_d;
  logic [43:0] ppn_q, ppn_d;
  logic        killed_q, killed_d;
  logic [XLEN-1:0] pte_q, pte_d;

  logic        pte_leaf, pte_nonleaf, pte_fault;
  logic [8:0]  vpn;
  logic [55:0] adr_full;
  logic        unused_inputs;

  ptecheck u_ptecheck (
    .pte_i     (HPTWReadPTE),
    .level_i   (level_q),
    .leaf_o    (pte_leaf),
    .nonleaf_o (pte_nonleaf),
    .fault_o   (pte_fault)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      level_q  <= '0;
      va_q     <= '0;
      side_q   <= 1'b0;
      ppn_q    <= '0;
      killed_q <= 1'b0;
      pte_q    <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      va_q     <= va_d;
      side_q   <= side_d;
      ppn_q    <= ppn_d;
      killed_q <= killed_d;
      pte_q    <= pte_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    va_d     = va_q;
    side_d   = side_q;
    ppn_d    = ppn_q;
    killed_d = killed_q;
    pte_d    = pte_q;
    case (state_q)
      S_IDLE: begin
        killed_d = 1'b0;
        if ((SATP_REGW[63:60] == SATP_MODE_SV39) && (DTLBMissM || ITLBMissF)) begin
          va_d    = DTLBMissM ? IEUAdrM[38:0] : PCF[38:0];
          side_d  = ~DTLBMissM;
          ppn_d   = SATP_REGW[43:0];
          level_d = PAGE_1G;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (HPTWGnt) begin
          state_d = S_WAIT;
          if (TLBFlush) killed_d = 1'b1;
        end else if (TLBFlush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (TLBFlush) killed_d = 1'b1;
        if (HPTWValid) begin
          // A flush seen anywhere after the grant drains the response silently.
          if (killed_q || TLBFlush) begin
            state_d = S_IDLE;
          end else if (pte_fault) begin
            state_d = S_FAULT;
          end else if (pte_nonleaf) begin
            ppn_d   = HPTWReadPTE[PTE_PPN_MSB:PTE_PPN_LSB];
            level_d = level_q - 2'd1;
            state_d = S_REQ;
          end else if (pte_leaf) begin
            pte_d   = HPTWReadPTE;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (level_q)
      PAGE_1G: vpn = va_q[38:30];
      PAGE_2M: vpn = va_q[29:21];
      default: vpn = va_q[20:12];
    endcase
    adr_full         = {ppn_q, vpn, 3'b000};
    HPTWAdr          = adr_full[PA_BITS-1:0];
    HPTWReq          = (state_q == S_REQ);
    SelHPTW          = (state_q != S_IDLE);
    // A flush landing on the final cycle still cancels the strobe.
    ITLBWriteF       = (state_q == S_WRITE) &  side_q & ~TLBFlush;
    DTLBWriteM       = (state_q == S_WRITE) & ~side_q & ~TLBFlush;
    WalkFault        = (state_q == S_FAULT) & ~TLBFlush;
    WalkFaultInstr   = (state_q == S_FAULT) & ~TLBFlush & side_q;
    PTE              = pte_q;
    PageTypeWriteVal = level_q;
  end

  assign unused_inputs = ^{SATP_REGW[59:44], PCF[XLEN-1:39], IEUAdrM[XLEN-1:39]};

endmodule

// File: tb/tb_ptw_sv39.sv
// Directed bench for ptw_sv39: 4K/1G walks, misaligned fault, D/I priority,
// delayed grant, flushes and asynchronous reset in the middle of a walk.
module tb_ptw_sv39;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] SATP_REGW = '0;
  logic        ITLBMissF = 1'b0;
  logic        DTLBMissM = 1'b0;
  logic [63:0] PCF = '0;
  logic [63:0] IEUAdrM = '0;
  logic        TLBFlush = 1'b0;
  logic        HPTWReq;
  logic [55:0] HPTWAdr;
  logic        HPTWGnt = 1'b0;
  logic        HPTWValid = 1'b0;
  logic [63:0] HPTWReadPTE = '0;
  logic        ITLBWriteF;
  logic        DTLBWriteM;
  logic [63:0] PTE;
  logic [1:0]  PageTypeWriteVal;
  logic        WalkFault;
  logic        WalkFaultInstr;
  logic        SelHPTW;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  time         t0;

  ptw_sv39 #(.PA_BITS(56), .XLEN(64)) dut (
    .clk              (clk),
    .reset            (reset),
    .SATP_REGW        (SATP_REGW),
    .ITLBMissF        (ITLBMissF),
    .DTLBMissM        (DTLBMissM),
    .PCF              (PCF),
    .IEUAdrM          (IEUAdrM),
    .TLBFlush         (TLBFlush),
    .HPTWReq          (HPTWReq),
    .HPTWAdr          (HPTWAdr),
    .HPTWGnt          (HPTWGnt),
    .HPTWValid        (HPTWValid),
    .HPTWReadPTE      (HPTWReadPTE),
    .ITLBWriteF       (ITLBWriteF),
    .DTLBWriteM       (DTLBWriteM),
    .PTE              (PTE),
    .PageTypeWriteVal (PageTypeWriteVal),
    .WalkFault        (WalkFault),
    .WalkFaultInstr   (WalkFaultInstr),
    .SelHPTW          (SelHPTW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sel"},  SelHPTW,    1'b0);
    chk({tag, "_itlb"}, ITLBWriteF, 1'b0);
    chk({tag, "_dtlb"}, DTLBWriteM, 1'b0);
    chk({tag, "_flt"},  WalkFault,  1'b0);
    chk({tag, "_req"},  HPTWReq,    1'b0);
  endtask

  // Called on a falling edge; returns on the falling edge after the response.
  task automatic serve(input string tag, input logic [55:0] exp_adr,
                       input logic [63:0] pte, input int unsigned gnt_dly);
    int unsigned t;
    t = 0;
    while (!HPTWReq && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_req"}, HPTWReq, 1'b1);
    chk({tag, "_adr"}, HPTWAdr, exp_adr);
    for (int unsigned i = 0; i < gnt_dly; i++) begin
      @(negedge clk);
      chk({tag, "_req_hold"}, HPTWReq, 1'b1);
      chk({tag, "_adr_hold"}, HPTWAdr, exp_adr);
    end
    HPTWGnt = 1'b1;
    @(negedge clk);
    HPTWGnt     = 1'b0;
    HPTWValid   = 1'b1;
    HPTWReadPTE = pte;
    @(negedge clk);
    HPTWValid   = 1'b0;
    HPTWReadPTE = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    SATP_REGW = {4'd8, 16'h0, 44'h8_0000};
    @(negedge clk);
    @(negedge clk);
    chk_idle("rst");
    chk("rst_adr", HPTWAdr, 56'h0);
    chk("rst_pte", PTE, 64'h0);
    chk("rst_type", PageTypeWriteVal, 2'b00);
    reset = 1'b1;
    @(negedge clk);

    // 4 KiB walk on the data side, immediate grant/valid.
    IEUAdrM = 64'h40_2030_1000;
    DTLBMissM = 1'b1;
    t0 = $time;
    @(negedge clk);
    DTLBMissM = 1'b0;
    chk("d4k_sel", SelHPTW, 1'b1);
    serve("d4k_l2", 56'h8000_0800, 64'h2000_0401, 0);
    serve("d4k_l1", 56'h8000_1808, 64'h2000_0801, 0);
    serve("d4k_l0", 56'h8000_2808, 64'h2000_0CCF, 0);
    chk("d4k_dwr", DTLBWriteM, 1'b1);
    chk("d4k_iwr", ITLBWriteF, 1'b0);
    chk("d4k_pte", PTE, 64'h2000_0CCF);
    chk("d4k_type", PageTypeWriteVal, 2'b00);
    chk("d4k_cycles", ($time - t0) / 10, 7);
    @(negedge clk);
    chk_idle("d4k_done");

    // 1 GiB leaf on the instruction side.
    PCF = 64'h8000_0000;
    ITLBMissF = 1'b1;
    t0 = $time;
    @(negedge clk);
    ITLBMissF = 1'b0;
    serve("i1g", 56'h8000_0010, 64'h2000_00CF, 0);
    chk("i1g_iwr", ITLBWriteF, 1'b1);
    chk("i1g_dwr", DTLBWriteM, 1'b0);
    chk("i1g_type", PageTypeWriteVal, 2'b10);
    chk("i1g_pte", PTE, 64'h2000_00CF);
    chk("i1g_cycles", ($time - t0) / 10, 3);
    @(negedge clk);
    chk_idle("i1g_done");

    // Misaligned 2 MiB leaf on the instruction side.
    PCF = 64'h40_2030_1000;
    ITLBMissF = 1'b1;
    @(negedge clk);
    ITLBMissF = 1'b0;
    serve("mis_l2", 56'h8000_0800, 64'h2000_0401, 0);
    serve("mis_l1", 56'h8000_1808, 64'h2000_04CF, 0);
    chk("mis_flt", WalkFault, 1'b1);
    chk("mis_fi", WalkFaultInstr, 1'b1);
    chk("mis_iwr", ITLBWriteF, 1'b0);
    chk("mis_dwr", DTLBWriteM, 1'b0);
    @(negedge clk);
    chk_idle("mis_done");

    // Simultaneous misses: data side first, then instruction side.
    IEUAdrM = 64'h40_2030_1000;
    PCF = 64'h8000_0000;
    DTLBMissM = 1'b1;
    ITLBMissF = 1'b1;
    @(negedge clk);
    DTLBMissM = 1'b0;
    serve("sim_d", 56'h8000_0800, 64'h2000_00CF, 0);
    chk("sim_d_dwr", DTLBWriteM, 1'b1);
    chk("sim_d_iwr", ITLBWriteF, 1'b0);
    @(negedge clk);
    chk("sim_gap_sel", SelHPTW, 1'b0);
    @(negedge clk);
    ITLBMissF = 1'b0;
    serve("sim_i", 56'h8000_0010, 64'h2000_00CF, 0);
    chk("sim_i_iwr", ITLBWriteF, 1'b1);
    chk("sim_i_dwr", DTLBWriteM, 1'b0);
    @(negedge clk);
    chk_idle("sim_done");

    // Grant delayed three cycles, then flush while waiting for data.
    IEUAdrM = 64'h40_2030_1000;
    DTLBMissM = 1'b1;
    @(negedge clk);
    DTLBMissM = 1'b0;
    chk("dly_req", HPTWReq, 1'b1);
    chk("dly_adr", HPTWAdr, 56'h8000_0800);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dly_req_hold", HPTWReq, 1'b1);
      chk("dly_adr_hold", HPTWAdr, 56'h8000_0800);
    end
    HPTWGnt = 1'b1;
    @(negedge clk);
    HPTWGnt = 1'b0;
    chk("dly_wait_req", HPTWReq, 1'b0);
    chk("dly_wait_sel", SelHPTW, 1'b1);
    TLBFlush = 1'b1;
    @(negedge clk);
    TLBFlush = 1'b0;
    chk("dly_killed_sel", SelHPTW, 1'b1);
    HPTWValid = 1'b1;
    HPTWReadPTE = 64'h2000_00CF;
    @(negedge clk);
    HPTWValid = 1'b0;
    HPTWReadPTE = '0;
    chk_idle("dly_flush");
    @(negedge clk);
    chk_idle("dly_after");

    // Flush in REQ before any grant drops straight back to IDLE.
    DTLBMissM = 1'b1;
    @(negedge clk);
    DTLBMissM = 1'b0;
    chk("fr_req", HPTWReq, 1'b1);
    TLBFlush = 1'b1;
    @(negedge clk);
    TLBFlush = 1'b0;
    chk_idle("fr_idle");

    // Asynchronous reset while waiting for read data.
    DTLBMissM = 1'b1;
    @(negedge clk);
    DTLBMissM = 1'b0;
    chk("rw_req", HPTWReq, 1'b1);
    HPTWGnt = 1'b1;
    @(negedge clk);
    HPTWGnt = 1'b0;
    chk("rw_wait_sel", SelHPTW, 1'b1);
    reset = 1'b0;
    #1;
    chk_idle("rw_rst");
    chk("rw_rst_adr", HPTWAdr, 56'h0);
    chk("rw_rst_pte", PTE, 64'h0);
    chk("rw_rst_type", PageTypeWriteVal, 2'b00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    HPTWValid = 1'b1;
    HPTWReadPTE = 64'h2000_00CF;
    @(negedge clk);
    HPTWValid = 1'b0;
    HPTWReadPTE = '0;
    chk_idle("rw_late_valid");
    chk("rw_late_pte", PTE, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
